// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative RV32M multiply/divide unit (shift-add / restoring divide) with pipeline stall control.
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_m, r_result;
  logic [2:0]          r_f3;
  logic                r_neg_q, r_neg_r;
  logic                w_accept, w_fast, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag, w_fast_res, w_fix_res, w_quo, w_rem;
  logic [XLEN:0]       w_sum, w_shr, w_diff;
  logic [2*XLEN-1:0]   w_mul_step, w_div_step, w_prod;

  assign w_accept = (r_state == IDLE) & i_start & ~i_flush;
  // Divide by zero and the single signed-overflow case bypass the iteration.
  assign w_fast = i_funct3[2] & ((i_rs2 == '0) |
                  (~i_funct3[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_rs2)));
  assign w_fast_res = (i_rs2 == '0) ? (i_funct3[1] ? i_rs1 : '1) : (i_funct3[1] ? '0 : i_rs1);
  assign w_a_neg = i_rs1[XLEN-1] & (i_funct3 == 3'b001 | i_funct3 == 3'b010 | i_funct3 == 3'b100 | i_funct3 == 3'b110);
  assign w_b_neg = i_rs2[XLEN-1] & (i_funct3 == 3'b001 | i_funct3 == 3'b100 | i_funct3 == 3'b110);
  assign w_a_mag = w_a_neg ? -i_rs1 : i_rs1;
  assign w_b_mag = w_b_neg ? -i_rs2 : i_rs2;

  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_step = {w_sum, r_acc[XLEN-1:1]};
  assign w_shr      = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = w_shr - {1'b0, r_m};
  assign w_div_step = w_diff[XLEN] ? {w_shr[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_fix_res = r_f3[2] ? (r_f3[1] ? w_rem : w_quo)
                             : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_accept ? (w_fast ? DONE : CALC) : IDLE;
      CALC: w_next = i_flush ? IDLE : ((r_cnt == CW'(XLEN-1)) ? FIX : CALC);
      FIX:  w_next = i_flush ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_f3     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= '0;
        r_f3    <= i_funct3;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_acc   <= {{XLEN{1'b0}}, i_funct3[2] ? w_a_mag : w_b_mag};
        r_m     <= i_funct3[2] ? w_b_mag : w_a_mag;
        if (w_fast) r_result <= w_fast_res;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_f3[2] ? w_div_step : w_mul_step;
      end else if (r_state == FIX && !i_flush) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign o_stall  = w_accept | (r_state == CALC) | (r_state == FIX);
  assign o_busy   = r_state != IDLE;
  assign o_done   = r_state == DONE;
  assign o_result = r_result;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors with hand-computed results, latency, stall, flush and reset checks.
module tb_muldiv_ctrl;
  logic        clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_flush = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_rs1 = '0, i_rs2 = '0;
  logic        o_stall, o_busy, o_done;
  logic [31:0] o_result;
  int n_cmp = 0, n_bad = 0;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_flush(i_flush), .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Caller is at a falling edge (cycle 0). dup_cyc>0 re-asserts i_start mid-operation with other operands.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input int dup_cyc);
    int lat = -1, bad_stall = 0;
    i_start = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b;
    #1 check({tag, " stall0"}, 32'(o_stall), 32'd1);
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      i_start = (k == dup_cyc);
      if (k == dup_cyc) begin i_funct3 = 3'b011; i_rs1 = '1; i_rs2 = '1; end
      #1;
      if (o_done) lat = k;
      if (o_done == o_stall) bad_stall++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, o_result, exp);
    check({tag, " stall"}, 32'(bad_stall), 32'd0);
    @(negedge clk);
    #1 check({tag, " idle"}, {30'd0, o_busy, o_done}, 32'd0);
    check({tag, " held"}, o_result, exp);
  endtask

  initial begin
    int saw_done;
    @(negedge clk); @(negedge clk);
    #1 check("rst outs", {o_result[30:0], o_stall} | {30'd0, o_busy, o_done}, 32'd0);
    rst = 1'b0;
    do_op("MUL",     3'b000, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 34, 0);
    do_op("MULHU",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    do_op("MULH",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 0);
    do_op("MULHSU",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 0);
    do_op("DIV",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
    do_op("REM",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
    do_op("DIVU",    3'b101, 32'd100,      32'd7,        32'd14,       34, 0);
    do_op("REMU",    3'b111, 32'd100,      32'd7,        32'd2,        34, 0);
    do_op("DIV0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    do_op("REM0",    3'b110, 32'd5,        32'd0,        32'd5,        1, 0);
    do_op("DIVU0",   3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1, 0);
    do_op("DIVOVF",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    do_op("REMOVF",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);
    do_op("DIVUBIG", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 0);
    do_op("MULDUP",  3'b000, 32'd3,        32'd5,        32'd15,       34, 5);
    // Flush mid-divide: no pulse, result kept, restart right away.
    saw_done = 0;
    i_start = 1'b1; i_funct3 = 3'b101; i_rs1 = 32'd100; i_rs2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_flush = (k == 10);
      #1 saw_done += int'(o_done);
    end
    @(negedge clk);
    i_flush = 1'b0;
    #1 check("flush idle", {30'd0, o_busy, o_done}, 32'd0);
    check("flush nodone", 32'(saw_done), 32'd0);
    check("flush held", o_result, 32'd15);
    do_op("REFILL", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);
    // Reset mid-multiply: outputs cleared immediately, operation discarded.
    saw_done = 0;
    i_start = 1'b1; i_funct3 = 3'b000; i_rs1 = 32'd6; i_rs2 = 32'd7;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    #1 check("pre-rst busy", 32'(o_busy), 32'd1);
    rst = 1'b1;
    #1 check("rst mid busy", {o_busy, o_stall, o_done}, 32'd0);
    check("rst mid result", o_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1 saw_done += int'(o_done | o_busy);
    end
    check("rst discard", 32'(saw_done), 32'd0);
    do_op("POSTRST", 3'b000, 32'd6, 32'd7, 32'd42, 34, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter XLEN, default 32: operand/result width and iteration count.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_start  input  1  request from EX stage: M-extension op present this cycle.
REQ-006 i_funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 i_rs1  input  XLEN  operand A (multiplicand/dividend).
REQ-008 i_rs2  input  XLEN  operand B (multiplier/divisor).
REQ-009 i_flush  input  1  abort current operation (branch/exception kill).
REQ-010 o_stall  output  1  hold pipeline stages IF..EX.
REQ-011 o_busy  output  1  operation in progress (state != IDLE).
REQ-012 o_done  output  1  one-cycle pulse; o_result valid.
REQ-013 o_result  output  XLEN  registered result, held until next o_done.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE; encoding free.
REQ-015 IDLE & i_start & !i_flush -> latch operands, funct3, signs; go CALC, iteration counter = 0.
REQ-016 IDLE & i_start with rs2==0 (DIV/DIVU/REM/REMU) or signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) -> go DONE directly (fast path, 1-cycle latency).
REQ-017 CALC SHALL perform exactly XLEN iterations (counter 0..XLEN-1), one per cycle: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-018 CALC at counter XLEN-1 -> FIX; FIX applies sign correction (two's-complement negate) and selects low/high product or quotient/remainder; FIX -> DONE.
REQ-019 DONE SHALL assert o_done for exactly one cycle, load o_result, then -> IDLE.
REQ-020 Normal latency: i_start sampled in cycle 0 -> CALC cycles 1..32 -> FIX cycle 33 -> o_done high cycle 34 -> IDLE cycle 35 (XLEN=32).
REQ-021 Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed; remainder takes dividend sign, quotient negative iff signs differ.
REQ-022 Multiply accumulator SHALL be 2*XLEN wide; MUL returns bits [XLEN-1:0], MULH* return [2*XLEN-1:XLEN].
REQ-023 Divide-by-zero: quotient = all ones, remainder = rs1.
REQ-024 Signed overflow: quotient = 0x80000000, remainder = 0.
REQ-025 o_stall = (IDLE & i_start & !i_flush) | CALC | FIX; low in DONE so EX/MEM captures result.
REQ-026 i_start while not IDLE SHALL be ignored; operands/funct3 latched only on IDLE acceptance.
REQ-027 i_flush in CALC or FIX -> IDLE next cycle, no o_done, o_result unchanged; i_flush in DONE does not suppress the pulse.
REQ-028 i_flush and i_start same cycle in IDLE -> request rejected, stays IDLE.
REQ-029 o_busy = (state != IDLE).

Reset
REQ-030 rst high SHALL immediately force IDLE, counter 0, o_done 0, o_stall 0, o_busy 0, o_result 0, internal registers 0.
REQ-031 rst asserted mid-operation SHALL discard the operation; no o_done after release.
REQ-032 First i_start SHALL be accepted on the first rising edge with rst low.

Verification
REQ-033 MUL rs1=7, rs2=0xFFFFFFFA (-6) -> o_done cycle 34, o_result 0xFFFFFFD6; o_stall high cycles 0..33.
REQ-034 MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
REQ-035 DIV rs1=-7, rs2=2 -> quotient 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-036 DIV rs1=5, rs2=0 -> o_done cycle 1, 0xFFFFFFFF; REM -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-037 Start DIVU, i_flush at cycle 10 -> IDLE cycle 11, no o_done, o_result unchanged; new start cycle 11 completes normally.
REQ-038 Start MUL, rst pulse at cycle 15 -> all outputs zero during reset; no o_done; second i_start during CALC ignored.
